// File: rtl/mem_stage.sv
// MEM stage of the LoongArch five-stage pipeline: waits for data-SRAM responses,
// extracts load data, forwards results to ID and drops responses orphaned by a WB flush.
module mem_stage #(
    parameter int DROP_W = 2
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         ex_mem_valid,
    input  logic [237:0] ex_mem_bus,
    output logic         mem_allowin,
    input  logic         wb_allowin,
    output logic         mem_wb_valid,
    output logic [231:0] mem_wb_bus,
    input  logic         data_sram_data_ok,
    input  logic [31:0]  data_sram_rdata,
    input  logic         wb_flush,
    input  logic         ex_drop_inc,
    output logic [39:0]  mem_fwd_bus,
    output logic         mem_ex_block
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_WAIT  = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    localparam logic [DROP_W:0] DROP_MAX = {1'b0, {DROP_W{1'b1}}};

    state_t              state_r;
    state_t              state_nxt_s;
    logic                mem_valid_r;
    logic                mem_valid_nxt_s;
    logic [4:0]          ld_op_r;
    logic [231:0]        wb_r;
    logic [31:0]         rdata_buf_r;
    logic                buf_cap_s;
    logic [DROP_W-1:0]   drop_cnt_r;
    logic [DROP_W-1:0]   drop_cnt_nxt_s;
    logic [DROP_W:0]     drop_sum_s;
    logic                drop_zero_s;
    logic                resp_ok_s;
    logic                mem_ready_go_s;
    logic                load_s;
    logic [31:0]         active_s;
    logic [7:0]          byte_s;
    logic [15:0]         half_s;
    logic [31:0]         final_s;
    logic                ld_block_s;
    logic                csr_block_s;

    assign drop_zero_s    = (drop_cnt_r == {DROP_W{1'b0}});
    assign resp_ok_s      = (state_r == ST_WAIT) & data_sram_data_ok & drop_zero_s;
    assign mem_ready_go_s = (state_r == ST_DONE) | resp_ok_s;
    assign mem_allowin    = ~mem_valid_r | (mem_ready_go_s & wb_allowin);
    assign mem_wb_valid   = mem_valid_r & mem_ready_go_s & ~wb_flush;
    assign load_s         = ex_mem_valid & mem_allowin & ~wb_flush;

    // Next-state logic: flush wins, then accepting EX, then draining, then buffering a response.
    always_comb begin
        state_nxt_s     = state_r;
        mem_valid_nxt_s = mem_valid_r;
        buf_cap_s       = 1'b0;
        if (wb_flush) begin
            state_nxt_s     = ST_EMPTY;
            mem_valid_nxt_s = 1'b0;
        end else if (load_s) begin
            mem_valid_nxt_s = 1'b1;
            state_nxt_s     = (ex_mem_bus[232] & ~ex_mem_bus[15]) ? ST_WAIT : ST_DONE;
        end else if (mem_allowin) begin
            state_nxt_s     = ST_EMPTY;
            mem_valid_nxt_s = 1'b0;
        end else if (resp_ok_s) begin
            state_nxt_s = ST_DONE;
            buf_cap_s   = 1'b1;
        end else begin
            state_nxt_s     = state_r;
            mem_valid_nxt_s = mem_valid_r;
        end
    end

    // Drop counter: a flushed WAIT instruction leaves one response in flight unless it arrives now.
    always_comb begin
        drop_sum_s = {1'b0, drop_cnt_r}
                   + {{DROP_W{1'b0}}, ex_drop_inc}
                   + {{DROP_W{1'b0}}, wb_flush & (state_r == ST_WAIT) & ~(data_sram_data_ok & drop_zero_s)}
                   - {{DROP_W{1'b0}}, data_sram_data_ok & ~drop_zero_s};
        if (drop_sum_s > DROP_MAX) begin
            drop_cnt_nxt_s = DROP_MAX[DROP_W-1:0];
        end else begin
            drop_cnt_nxt_s = drop_sum_s[DROP_W-1:0];
        end
    end

    // State, valid, drop counter and buffered response registers.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= ST_EMPTY;
            mem_valid_r <= 1'b0;
            drop_cnt_r  <= {DROP_W{1'b0}};
            rdata_buf_r <= 32'h0000_0000;
        end else begin
            state_r     <= state_nxt_s;
            mem_valid_r <= mem_valid_nxt_s;
            drop_cnt_r  <= drop_cnt_nxt_s;
            if (buf_cap_s) begin
                rdata_buf_r <= data_sram_rdata;
            end
        end
    end

    // EX->MEM bus register; req_sent only steers the FSM and is not kept.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ld_op_r <= 5'b0_0000;
            wb_r    <= 232'd0;
        end else if (load_s) begin
            ld_op_r <= ex_mem_bus[237:233];
            wb_r    <= ex_mem_bus[231:0];
        end
    end

    // In WAIT the response is used directly; after buffering it comes from rdata_buf.
    assign active_s = (state_r == ST_WAIT) ? data_sram_rdata : rdata_buf_r;

    // Load extraction; offset is the address held in the final_result slot.
    always_comb begin
        case (wb_r[136:135])
            2'b00:   byte_s = active_s[7:0];
            2'b01:   byte_s = active_s[15:8];
            2'b10:   byte_s = active_s[23:16];
            2'b11:   byte_s = active_s[31:24];
            default: byte_s = 8'h00;
        endcase
        if (wb_r[136]) begin
            half_s = active_s[31:16];
        end else begin
            half_s = active_s[15:0];
        end
        case (ld_op_r)
            5'b10000: final_s = {{24{byte_s[7]}}, byte_s};
            5'b01000: final_s = {24'h00_0000, byte_s};
            5'b00100: final_s = {{16{half_s[15]}}, half_s};
            5'b00010: final_s = {16'h0000, half_s};
            5'b00001: final_s = active_s;
            default:  final_s = wb_r[166:135];
        endcase
    end

    assign ld_block_s   = mem_valid_r & (|ld_op_r) & ~mem_ready_go_s;
    assign csr_block_s  = mem_valid_r & (wb_r[129] | wb_r[128]);
    assign mem_wb_bus   = {wb_r[231:167], final_s, wb_r[134:0]};
    assign mem_fwd_bus  = {mem_valid_r & wb_r[231], wb_r[134:130], final_s, ld_block_s, csr_block_s};
    assign mem_ex_block = mem_valid_r & (wb_r[15] | wb_r[49]);

    mem_stage_chk #(.DROP_W(DROP_W)) u_chk (
        .clk      (clk),
        .resetn   (resetn),
        .drop_cnt (drop_cnt_r)
    );

endmodule

// Checker for mem_stage: the stale-response counter must never reach its ceiling.
module mem_stage_chk #(
    parameter int DROP_W = 2
) (
    input logic              clk,
    input logic              resetn,
    input logic [DROP_W-1:0] drop_cnt
);

    a_drop_below_max: assert property (@(posedge clk) disable iff (!resetn)
        drop_cnt != {DROP_W{1'b1}})
        else $error("mem_stage: drop counter reached its limit");

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: a queue-based scoreboard checks every WB transfer,
// while the main thread checks handshake, forwarding and drop-counter behaviour.
module tb_mem_stage;

    logic         clk = 1'b0;
    logic         resetn;
    logic         ex_mem_valid;
    logic [237:0] ex_mem_bus;
    logic         mem_allowin;
    logic         wb_allowin;
    logic         mem_wb_valid;
    logic [231:0] mem_wb_bus;
    logic         data_sram_data_ok;
    logic [31:0]  data_sram_rdata;
    logic         wb_flush;
    logic         ex_drop_inc;
    logic [39:0]  mem_fwd_bus;
    logic         mem_ex_block;

    int n_checks = 0;
    int n_errors = 0;
    logic [231:0] exp_q[$];

    mem_stage #(.DROP_W(2)) dut (
        .clk               (clk),
        .resetn            (resetn),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_bus        (ex_mem_bus),
        .mem_allowin       (mem_allowin),
        .wb_allowin        (wb_allowin),
        .mem_wb_valid      (mem_wb_valid),
        .mem_wb_bus        (mem_wb_bus),
        .data_sram_data_ok (data_sram_data_ok),
        .data_sram_rdata   (data_sram_rdata),
        .wb_flush          (wb_flush),
        .ex_drop_inc       (ex_drop_inc),
        .mem_fwd_bus       (mem_fwd_bus),
        .mem_ex_block      (mem_ex_block)
    );

    always #5 clk = ~clk;

    function automatic logic [231:0] mk_wb(input logic gr_we, input logic [31:0] pc,
                                           input logic [31:0] res, input logic [4:0] dest,
                                           input logic ex);
        mk_wb = {gr_we, pc, 32'h0280_0000, res, dest, 1'b0, 1'b0, 14'h0000,
                 32'h0000_0000, 32'h0000_0000, 1'b0, 1'b0, 32'h0000_0000, ex, 9'h000, 6'h00};
    endfunction

    function automatic logic [237:0] mk_bus(input logic [4:0] ld, input logic rs,
                                            input logic gr_we, input logic [31:0] pc,
                                            input logic [31:0] res, input logic [4:0] dest,
                                            input logic ex);
        mk_bus = {ld, rs, mk_wb(gr_we, pc, res, dest, ex)};
    endfunction

    task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compare each accepted WB transfer with the oldest expectation.
    always @(negedge clk) begin
        if (resetn && mem_wb_valid && wb_allowin) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL wb_unexpected: got %h with no expected entry", mem_wb_bus);
            end else begin
                logic [231:0] e;
                e = exp_q.pop_front();
                if (mem_wb_bus !== e) begin
                    n_errors++;
                    $display("FAIL wb_bus: got result %h pc %h, expected result %h pc %h",
                             mem_wb_bus[166:135], mem_wb_bus[230:199], e[166:135], e[230:199]);
                end
            end
        end
    end

    initial begin
        resetn            = 1'b0;
        ex_mem_valid      = 1'b0;
        ex_mem_bus        = 238'd0;
        wb_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0000_0000;
        wb_flush          = 1'b0;
        ex_drop_inc       = 1'b0;

        #2;
        check("rst_allowin", {39'd0, mem_allowin}, 40'd1);
        check("rst_wb_valid", {39'd0, mem_wb_valid}, 40'd0);
        check("rst_wb_bus_zero", {39'd0, |mem_wb_bus}, 40'd0);
        check("rst_fwd_bus", mem_fwd_bus, 40'd0);
        check("rst_ex_block", {39'd0, mem_ex_block}, 40'd0);
        tick();
        tick();
        resetn = 1'b1;

        // ALU op, no request
        ex_mem_bus   = mk_bus(5'b00000, 1'b0, 1'b1, 32'h1C00_0000, 32'h0000_1234, 5'd5, 1'b0);
        ex_mem_valid = 1'b1;
        exp_q.push_back(mk_wb(1'b1, 32'h1C00_0000, 32'h0000_1234, 5'd5, 1'b0));
        @(negedge clk);
        check("alu_allowin_before", {39'd0, mem_allowin}, 40'd1);
        tick();
        ex_mem_valid = 1'b0;
        @(negedge clk);
        check("alu_wb_valid", {39'd0, mem_wb_valid}, 40'd1);
        check("alu_allowin", {39'd0, mem_allowin}, 40'd1);
        check("alu_fwd", mem_fwd_bus, {1'b1, 5'd5, 32'h0000_1234, 1'b0, 1'b0});
        tick();
        @(negedge clk);
        check("alu_drained", {39'd0, mem_wb_valid}, 40'd0);

        // Exception instruction with req_sent: goes straight to DONE and blocks EX stores
        ex_mem_bus   = mk_bus(5'b00000, 1'b1, 1'b1, 32'h1C00_0004, 32'h0000_0077, 5'd7, 1'b1);
        ex_mem_valid = 1'b1;
        exp_q.push_back(mk_wb(1'b1, 32'h1C00_0004, 32'h0000_0077, 5'd7, 1'b1));
        tick();
        ex_mem_valid = 1'b0;
        @(negedge clk);
        check("ex_state_done", {38'd0, dut.state_r}, 40'd2);
        check("ex_block", {39'd0, mem_ex_block}, 40'd1);
        tick();

        // ld.b at offset 3, response three cycles after acceptance
        ex_mem_bus   = mk_bus(5'b10000, 1'b1, 1'b1, 32'h1C00_0008, 32'h1000_0003, 5'd6, 1'b0);
        ex_mem_valid = 1'b1;
        exp_q.push_back(mk_wb(1'b1, 32'h1C00_0008, 32'hFFFF_FF80, 5'd6, 1'b0));
        tick();
        ex_mem_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("ldb_block_wait", {39'd0, mem_fwd_bus[1]}, 40'd1);
            check("ldb_no_valid_wait", {39'd0, mem_wb_valid}, 40'd0);
            tick();
        end
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h80FF_FF00;
        @(negedge clk);
        check("ldb_block_released", {39'd0, mem_fwd_bus[1]}, 40'd0);
        check("ldb_wb_valid", {39'd0, mem_wb_valid}, 40'd1);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0000_0000;

        // ld.hu at offset 2, response buffered while WB stalls
        ex_mem_bus   = mk_bus(5'b00010, 1'b1, 1'b1, 32'h1C00_000C, 32'h2000_0002, 5'd8, 1'b0);
        ex_mem_valid = 1'b1;
        exp_q.push_back(mk_wb(1'b1, 32'h1C00_000C, 32'h0000_ABCD, 5'd8, 1'b0));
        tick();
        ex_mem_valid      = 1'b0;
        wb_allowin        = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'hABCD_0000;
        @(negedge clk);
        check("ldhu_stall_allowin", {39'd0, mem_allowin}, 40'd0);
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h1111_2222;
        @(negedge clk);
        check("ldhu_state_done", {38'd0, dut.state_r}, 40'd2);
        check("ldhu_valid_held", {39'd0, mem_wb_valid}, 40'd1);
        tick();
        wb_allowin = 1'b1;
        @(negedge clk);
        check("ldhu_allowin", {39'd0, mem_allowin}, 40'd1);
        tick();

        // Flush in WAIT leaves a stale response; it must not disturb the next ALU op
        ex_mem_bus   = mk_bus(5'b00001, 1'b1, 1'b1, 32'h1C00_0010, 32'h3000_0000, 5'd9, 1'b0);
        ex_mem_valid = 1'b1;
        tick();
        ex_mem_valid = 1'b0;
        wb_flush     = 1'b1;
        @(negedge clk);
        check("flush_no_valid", {39'd0, mem_wb_valid}, 40'd0);
        tick();
        wb_flush     = 1'b0;
        ex_mem_bus   = mk_bus(5'b00000, 1'b0, 1'b1, 32'h1C00_0014, 32'h0000_5555, 5'd10, 1'b0);
        ex_mem_valid = 1'b1;
        exp_q.push_back(mk_wb(1'b1, 32'h1C00_0014, 32'h0000_5555, 5'd10, 1'b0));
        @(negedge clk);
        check("flush_drop_cnt", {38'd0, dut.drop_cnt_r}, 40'd1);
        check("flush_state_empty", {38'd0, dut.state_r}, 40'd0);
        tick();
        ex_mem_valid      = 1'b0;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0000_DEAD;
        tick();
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = 32'h0000_0000;
        @(negedge clk);
        check("stale_drop_cnt", {38'd0, dut.drop_cnt_r}, 40'd0);
        check("stale_no_valid", {39'd0, mem_wb_valid}, 40'd0);

        // Flush and response together, plus an EX-side drop
        ex_mem_bus   = mk_bus(5'b00001, 1'b1, 1'b1, 32'h1C00_0018, 32'h3000_0004, 5'd11, 1'b0);
        ex_mem_valid = 1'b1;
        tick();
        ex_mem_valid      = 1'b0;
        wb_flush          = 1'b1;
        data_sram_data_ok = 1'b1;
        data_sram_rdata   = 32'h0BAD_0BAD;
        ex_drop_inc       = 1'b1;
        @(negedge clk);
        check("flush_ok_no_valid", {39'd0, mem_wb_valid}, 40'd0);
        tick();
        wb_flush          = 1'b0;
        data_sram_data_ok = 1'b0;
        ex_drop_inc       = 1'b0;
        @(negedge clk);
        check("flush_ok_drop_cnt", {38'd0, dut.drop_cnt_r}, 40'd1);
        check("flush_ok_mem_valid", {39'd0, dut.mem_valid_r}, 40'd0);

        // Build up WAIT with drop_cnt=2, then assert reset asynchronously
        ex_mem_bus   = mk_bus(5'b00001, 1'b1, 1'b1, 32'h1C00_001C, 32'h3000_0008, 5'd12, 1'b0);
        ex_mem_valid = 1'b1;
        tick();
        ex_mem_valid = 1'b0;
        wb_flush     = 1'b1;
        tick();
        wb_flush     = 1'b0;
        ex_mem_bus   = mk_bus(5'b00001, 1'b1, 1'b1, 32'h1C00_0020, 32'h3000_000C, 5'd13, 1'b0);
        ex_mem_valid = 1'b1;
        tick();
        ex_mem_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_drop_cnt", {38'd0, dut.drop_cnt_r}, 40'd2);
        check("pre_rst_state_wait", {38'd0, dut.state_r}, 40'd1);
        check("pre_rst_ld_block", {39'd0, mem_fwd_bus[1]}, 40'd1);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_state", {38'd0, dut.state_r}, 40'd0);
        check("arst_drop_cnt", {38'd0, dut.drop_cnt_r}, 40'd0);
        check("arst_wb_valid", {39'd0, mem_wb_valid}, 40'd0);
        check("arst_allowin", {39'd0, mem_allowin}, 40'd1);

        check("scoreboard_drained", 40'(exp_q.size()), 40'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
